// File: rtl/enum_state_checker.sv
// Receive-side protocol monitor for the IDLE->ACTIVE->WAIT->DONE state stream.
// Locks on IDLE, checks each valid sample against the expected successor, counts sequences and errors.
module enum_state_checker #(
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 4,
  parameter int ALLOW_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             valid,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       expected,
  output logic             err_pulse,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] DONE   = 2'b11;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t      state_q,       state_d;
  logic [1:0]       expected_q,    expected_d;
  logic [1:0]       prev_q,        prev_d;
  logic             err_pulse_q,   err_pulse_d;
  logic             fault_q,       fault_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [ERR_W-1:0] err_count_q,   err_count_d;

  function automatic logic [1:0] successor(input logic [1:0] code);
    return code + 2'd1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the branches below leaves one unassigned and infers a latch.
    state_d       = state_q;
    expected_d    = expected_q;
    prev_d        = prev_q;
    err_pulse_d   = 1'b0;
    fault_d       = fault_q;
    cycle_count_d = cycle_count_q;
    err_count_d   = err_count_q;

    if (valid) begin
      prev_d = state_in;
      if (state_q == UNLOCKED) begin
        if (state_in == IDLE) begin
          state_d    = LOCKED;
          expected_d = ACTIVE;
        end
      end else if (state_in == expected_q) begin
        expected_d = successor(state_in);
        if (state_in == DONE) cycle_count_d = cycle_count_q + CNT_W'(1);
      end else if (!((ALLOW_HOLD != 0) && (state_in == prev_q))) begin
        err_pulse_d = 1'b1;
        fault_d     = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
        // An unexpected IDLE is taken as the start of a fresh sequence.
        if (state_in == IDLE) begin
          expected_d = ACTIVE;
        end else begin
          state_d    = UNLOCKED;
          expected_d = 2'b00;
        end
      end
    end

    // Clear overrides counter/fault updates but leaves the lock FSM alone.
    if (clear) begin
      fault_d       = 1'b0;
      cycle_count_d = '0;
      err_count_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      expected_q    <= 2'b00;
      prev_q        <= 2'b00;
      err_pulse_q   <= 1'b0;
      fault_q       <= 1'b0;
      cycle_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      prev_q        <= prev_d;
      err_pulse_q   <= err_pulse_d;
      fault_q       <= fault_d;
      cycle_count_q <= cycle_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign expected    = expected_q;
  assign err_pulse   = err_pulse_q;
  assign fault       = fault_q;
  assign cycle_count = cycle_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_enum_state_checker.sv
// Directed bench for enum_state_checker: one instance with stalls disallowed, one with stalls allowed,
// both fed the same stream.
module tb_enum_state_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_in;
  logic       valid;
  logic       clear;

  logic       a_locked, a_err_pulse, a_fault;
  logic [1:0] a_expected;
  logic [7:0] a_cycle_count;
  logic [3:0] a_err_count;

  logic       h_locked, h_err_pulse, h_fault;
  logic [1:0] h_expected;
  logic [7:0] h_cycle_count;
  logic [3:0] h_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enum_state_checker #(.CNT_W(8), .ERR_W(4), .ALLOW_HOLD(0)) dut_a (
    .clk(clk), .reset(reset), .state_in(state_in), .valid(valid), .clear(clear),
    .locked(a_locked), .expected(a_expected), .err_pulse(a_err_pulse), .fault(a_fault),
    .cycle_count(a_cycle_count), .err_count(a_err_count)
  );

  enum_state_checker #(.CNT_W(8), .ERR_W(4), .ALLOW_HOLD(1)) dut_h (
    .clk(clk), .reset(reset), .state_in(state_in), .valid(valid), .clear(clear),
    .locked(h_locked), .expected(h_expected), .err_pulse(h_err_pulse), .fault(h_fault),
    .cycle_count(h_cycle_count), .err_count(h_err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, then look at the outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] s);
    valid    = v;
    state_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_locked"}, a_locked, 0);
    check({tag, "_expected"}, a_expected, 0);
    check({tag, "_err_pulse"}, a_err_pulse, 0);
    check({tag, "_fault"}, a_fault, 0);
    check({tag, "_cycle_count"}, a_cycle_count, 0);
    check({tag, "_err_count"}, a_err_count, 0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; clear = 1'b0; state_in = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    check_a_reset("reset");
    reset = 1'b0;

    // Clean sequence 00,01,10,11,00.
    step(1, 2'b00);
    check("seq0_locked", a_locked, 1);
    check("seq0_expected", a_expected, 2'b01);
    step(1, 2'b01);
    check("seq1_expected", a_expected, 2'b10);
    step(1, 2'b10);
    check("seq2_expected", a_expected, 2'b11);
    step(1, 2'b11);
    check("seq3_expected", a_expected, 2'b00);
    check("seq3_cycle_count", a_cycle_count, 1);
    step(1, 2'b00);
    check("seq4_expected", a_expected, 2'b01);
    check("seq4_err_pulse", a_err_pulse, 0);
    check("seq4_err_count", a_err_count, 0);

    // Expecting 10, drive 11: drop lock.
    step(1, 2'b01);
    step(1, 2'b11);
    check("skip_err_pulse", a_err_pulse, 1);
    check("skip_fault", a_fault, 1);
    check("skip_err_count", a_err_count, 1);
    check("skip_locked", a_locked, 0);
    check("skip_expected", a_expected, 2'b00);
    step(0, 2'b11);
    check("skip_pulse_one_cycle", a_err_pulse, 0);
    check("skip_fault_sticky", a_fault, 1);
    step(1, 2'b00);
    check("relock_locked", a_locked, 1);
    check("relock_expected", a_expected, 2'b01);

    // Expecting 11, drive 00: resync, stay locked.
    step(1, 2'b01);
    step(1, 2'b10);
    step(1, 2'b00);
    check("resync_err_pulse", a_err_pulse, 1);
    check("resync_err_count", a_err_count, 2);
    check("resync_locked", a_locked, 1);
    check("resync_expected", a_expected, 2'b01);
    step(1, 2'b01);
    check("resync_pulse_low", a_err_pulse, 0);
    step(1, 2'b10);
    step(1, 2'b11);
    check("resync_cycle_count", a_cycle_count, 2);

    // valid=0 gap: everything holds.
    step(0, 2'b10);
    step(0, 2'b01);
    check("gap_locked", a_locked, 1);
    check("gap_expected", a_expected, 2'b00);
    check("gap_cycle_count", a_cycle_count, 2);
    check("gap_err_pulse", a_err_pulse, 0);
    step(1, 2'b00);
    check("gap_resume_expected", a_expected, 2'b01);
    check("gap_resume_err_count", a_err_count, 2);

    // Reset mid-sequence with valid high.
    reset = 1'b1;
    step(1, 2'b01);
    reset = 1'b0;
    check_a_reset("midreset");

    // Hold stream 00,01,01,01,10,11 on both instances.
    step(1, 2'b00);
    step(1, 2'b01);
    step(1, 2'b01);
    check("hold0_a_err_pulse", a_err_pulse, 1);
    check("hold0_a_locked", a_locked, 0);
    check("hold1_h_err_pulse", h_err_pulse, 0);
    step(1, 2'b01);
    check("hold0_a_unlocked_no_err", a_err_pulse, 0);
    step(1, 2'b10);
    step(1, 2'b11);
    check("hold0_a_err_count", a_err_count, 1);
    check("hold0_a_cycle_count", a_cycle_count, 0);
    check("hold1_h_err_count", h_err_count, 0);
    check("hold1_h_fault", h_fault, 0);
    check("hold1_h_cycle_count", h_cycle_count, 1);
    check("hold1_h_locked", h_locked, 1);
    check("hold1_h_expected", h_expected, 2'b00);

    // Clear coinciding with an error sample.
    step(1, 2'b00);
    clear = 1'b1;
    step(1, 2'b11);
    clear = 1'b0;
    check("clr_err_pulse", a_err_pulse, 1);
    check("clr_fault", a_fault, 0);
    check("clr_err_count", a_err_count, 0);
    check("clr_locked", a_locked, 0);
    check("clr_h_cycle_count", h_cycle_count, 0);

    // Error counter saturation: repeated IDLE while locked is an error each time.
    step(1, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b00);
      if (i == 14) check("sat_reach_15", a_err_count, 15);
    end
    check("sat_err_count", a_err_count, 15);
    check("sat_err_pulse_back_to_back", a_err_pulse, 1);
    check("sat_locked", a_locked, 1);
    check("sat_expected", a_expected, 2'b01);

    // Sequence counter wrap after 256 sequences.
    reset = 1'b1;
    step(0, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1, 2'b00);
      step(1, 2'b01);
      step(1, 2'b10);
      step(1, 2'b11);
      if (i == 254) check("wrap_255", a_cycle_count, 255);
    end
    check("wrap_cycle_count", a_cycle_count, 0);
    check("wrap_err_count", a_err_count, 0);
    check("wrap_fault", a_fault, 0);

    // Clear coinciding with a DONE sample.
    step(1, 2'b00);
    step(1, 2'b01);
    step(1, 2'b10);
    clear = 1'b1;
    step(1, 2'b11);
    clear = 1'b0;
    check("clr_done_cycle_count", a_cycle_count, 0);
    check("clr_done_expected", a_expected, 2'b00);
    check("clr_done_locked", a_locked, 1);
    check("clr_done_err_pulse", a_err_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enum_state_checker.md
Name: enum_state_checker

Overview:
- Receive-side monitor for the 2-bit enumerated state stream driven by the four-state sequencer (IDLE=2'b00, ACTIVE=2'b01, WAIT=2'b10, DONE=2'b11; legal order IDLE->ACTIVE->WAIT->DONE->IDLE).
- Samples the stream, locks onto the sequence and checks every sampled transition against the expected next state.
- Counts completed sequences and illegal transitions.
- Sits downstream of the sequencer's state output; used as an in-design protocol checker and a bench scoreboard.

Parameters:
- CNT_W, 8, width of the completed-sequence counter (wraps).
- ERR_W, 4, width of the error counter (saturates).
- ALLOW_HOLD, 0, when 1 a sample equal to the previous sample is legal (stall); when 0 it is an error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- state_in  input  2  observed state code
- valid  input  1  state_in is sampled only when 1
- clear  input  1  synchronous clear of counters and sticky fault (not of lock FSM)
- locked  output  1  1 while in LOCKED
- expected  output  2  next code expected in LOCKED; 2'b00 otherwise
- err_pulse  output  1  one-cycle pulse per illegal transition
- fault  output  1  sticky error flag
- cycle_count  output  CNT_W  number of DONE samples accepted in LOCKED
- err_count  output  ERR_W  number of errors, saturating at all-ones

Behaviour:
- All outputs registered. A result appears on the outputs in the cycle after the sampling edge, i.e. 1-cycle latency.
- reset (sampled at posedge clk) forces:
  - FSM=UNLOCKED, locked=0, expected=2'b00, err_pulse=0
  - fault=0, cycle_count=0, err_count=0, prev=2'b00
- reset has priority over clear and valid; reset mid-sequence drops lock immediately.
- valid=0: FSM, expected, prev and counters hold; err_pulse=0.
- FSM states are UNLOCKED and LOCKED.
- UNLOCKED:
  - valid && state_in==IDLE -> LOCKED, expected<=ACTIVE.
  - Any other valid code stays UNLOCKED; it is not an error.
- LOCKED, on valid:
  - state_in==expected: expected<=successor(state_in) (DONE wraps to IDLE). If state_in==DONE, cycle_count<=cycle_count+1, wrapping mod 2^CNT_W.
  - ALLOW_HOLD==1 && state_in==prev: legal stall; no state change.
  - Otherwise error:
    - err_pulse<=1, fault<=1
    - err_count<=err_count+1 unless all-ones
    - if state_in==IDLE: stay LOCKED (resync), expected<=ACTIVE; else -> UNLOCKED, expected<=2'b00.
  - With ALLOW_HOLD==0 a repeated code is an error.
- prev<=state_in on every valid sample, in both states.
- clear (no reset):
  - cycle_count<=0, err_count<=0, fault<=0.
  - If an error or DONE is sampled in the same cycle, clear wins for fault and both counters; err_pulse still fires and FSM/expected still update.
- successor(): 00->01, 01->10, 10->11, 11->00. Pure 2-bit increment with wrap.
- err_pulse is never high two cycles in a row unless two consecutive valid samples are both errors.

Test Plan:
- Reset, then valid=1 with state_in 00,01,10,11,00 -> locked=1 from the cycle after the first 00; expected 01,10,11,00,01; cycle_count=1; err_pulse never high.
- Locked and expecting 10, drive 11 -> err_pulse=1 for exactly one cycle, fault=1, err_count=1, locked=0, expected=00. Then drive 00 -> relock with expected=01.
- Locked and expecting 11, drive 00 -> err_count increments, locked stays 1, expected=01. Then 01,10,11 -> cycle_count increments.
- ALLOW_HOLD=1, drive 00,01,01,01,10,11 -> no errors, cycle_count=1. Same stimulus with ALLOW_HOLD=0 -> err_pulse on the first repeated 01, err_count=1.
- Inject 20 errors with ERR_W=4 -> err_count saturates at 15. Run 256 full sequences with CNT_W=8 -> cycle_count wraps to 0.
- Two further cases:
  - Assert clear in the same cycle as an error sample -> counters=0, fault=0, err_pulse=1.
  - Assert reset mid-sequence with valid=1 -> next cycle all outputs at reset values; valid=0 gaps mid-sequence -> outputs hold.
